// File: rtl/ifu_iccm_ecc_scrub_pkg.sv
// Shared constants, scrub FSM states and SECDED helper functions for the
// ICCM read-line check/correct and scrub-write block.
package ifu_iccm_ecc_scrub_pkg;

  localparam int CW_W   = 39;
  localparam int DATA_W = 32;
  localparam int LINE_W = 156;
  localparam int WORDS  = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } scrub_state_e;

  // Hamming position -> codeword bit: powers of two hold ecc[5:0],
  // position 0 stands for the overall parity bit ecc[6] at bit 38.
  function automatic logic [5:0] pos_to_bit(input logic [5:0] pos);
    logic [5:0] idx;
    case (pos) inside
      6'd1:           idx = 6'd32;
      6'd2:           idx = 6'd33;
      6'd3:           idx = 6'd0;
      6'd4:           idx = 6'd34;
      [6'd5:6'd7]:    idx = pos - 6'd4;
      6'd8:           idx = 6'd35;
      [6'd9:6'd15]:   idx = pos - 6'd5;
      6'd16:          idx = 6'd36;
      [6'd17:6'd31]:  idx = pos - 6'd6;
      6'd32:          idx = 6'd37;
      [6'd33:6'd38]:  idx = pos - 6'd7;
      default:        idx = 6'd38;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] idx;
    if (m[0]) begin
      idx = 2'd0;
    end else if (m[1]) begin
      idx = 2'd1;
    end else if (m[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ifu_iccm_ecc_scrub_dec.sv
// Combinational SECDED check/correct of one 39-bit ICCM codeword
// ([31:0] data, [38:32] ecc).
module ifu_iccm_ecc_dec
  import ifu_iccm_ecc_scrub_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [CW_W-1:0] cw_fix,
  output logic            sb,
  output logic            db
);

  logic [CW_W-1:0] pv_s;
  logic [5:0]      syn_s;
  logic            par_s;

  // Codeword reordered by Hamming position (bit p = position p, bit 0 = ecc[6]).
  assign pv_s = {cw[31:26], cw[37], cw[25:11], cw[36], cw[10:4], cw[35],
                 cw[3:1], cw[34], cw[0], cw[33], cw[32], cw[38]};
  assign par_s = ^cw;

  // Syndrome: includes the stored ecc bit, so it is recomputed XOR stored.
  always_comb begin
    syn_s = 6'b0;
    for (int p = 1; p < CW_W; p++) begin
      for (int k = 0; k < 6; k++) begin
        if (p[k]) begin
          syn_s[k] = syn_s[k] ^ pv_s[p];
        end else begin
          syn_s[k] = syn_s[k];
        end
      end
    end
  end

  // Classify and flip the single failing bit.
  always_comb begin
    sb = par_s && (syn_s <= 6'd38);
    db = (par_s && (syn_s > 6'd38)) || (!par_s && (syn_s != 6'd0));
    if (sb) begin
      cw_fix = cw ^ (39'b1 << pos_to_bit(syn_s));
    end else begin
      cw_fix = cw;
    end
  end

endmodule

// File: rtl/ifu_iccm_ecc_scrub.sv
// ICCM read-line SECDED correction with registered fetch data and a
// req/gnt scrub-write queue for corrected single-bit codewords.
module ifu_iccm_ecc_scrub
  import ifu_iccm_ecc_scrub_pkg::*;
#(
  parameter int ICCM_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  rd_req_valid,
  input  logic [ICCM_BITS-3:0]  rd_req_addr,
  input  logic [LINE_W-1:0]     iccm_rd_data,
  output logic                  rd_valid,
  output logic [127:0]          rd_data,
  output logic [3:0]            rd_sb_err,
  output logic [3:0]            rd_db_err,
  output logic                  wb_req,
  output logic [ICCM_BITS-3:0]  wb_addr,
  output logic [2:0]            wb_size,
  output logic [77:0]           wb_data,
  input  logic                  wb_gnt,
  output logic [15:0]           sb_cnt,
  output logic [15:0]           db_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int AW = ICCM_BITS - 2;
  localparam int LW = ICCM_BITS - 4;

  logic                       req_valid_r;
  logic [AW-1:0]              req_addr_r;
  logic [WORDS-1:0][CW_W-1:0] cw_fix_s;
  logic [WORDS-1:0]           sb_s;
  logic [WORDS-1:0]           db_s;
  logic [127:0]               data_s;
  logic [3:0]                 sb_mask_s;
  logic [3:0]                 db_mask_s;
  logic                       unused_addr_s;

  scrub_state_e               state_r, state_n;
  logic [3:0]                 pend_r, pend_n;
  logic [WORDS-1:0][CW_W-1:0] cws_r, cws_n;
  logic [LW-1:0]              line_r, line_n;
  logic [1:0]                 idx_n;
  logic                       drop_s;

  assign wb_size       = 3'b010;
  assign unused_addr_s = ^req_addr_r[1:0];

  for (genvar w = 0; w < WORDS; w++) begin : g_dec
    ifu_iccm_ecc_dec u_dec (
      .cw     (iccm_rd_data[w*CW_W +: CW_W]),
      .cw_fix (cw_fix_s[w]),
      .sb     (sb_s[w]),
      .db     (db_s[w])
    );
  end

  // Corrected data words packed into the fetch line.
  always_comb begin
    data_s = 128'b0;
    for (int w = 0; w < WORDS; w++) begin
      data_s[w*DATA_W +: DATA_W] = cw_fix_s[w][DATA_W-1:0];
    end
  end

  assign sb_mask_s = req_valid_r ? (sb_s & ~db_s) : 4'b0;
  assign db_mask_s = req_valid_r ? db_s : 4'b0;

  // Read-address stage: the line data arrives one cycle after the request.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_valid_r <= 1'b0;
      req_addr_r  <= '0;
    end else begin
      req_valid_r <= rd_req_valid;
      req_addr_r  <= rd_req_valid ? rd_req_addr : req_addr_r;
    end
  end

  // Registered fetch result.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_valid  <= 1'b0;
      rd_data   <= 128'b0;
      rd_sb_err <= 4'b0;
      rd_db_err <= 4'b0;
    end else if (req_valid_r) begin
      rd_valid  <= 1'b1;
      rd_data   <= data_s;
      rd_sb_err <= sb_s;
      rd_db_err <= db_s;
    end else begin
      rd_valid  <= 1'b0;
      rd_data   <= rd_data;
      rd_sb_err <= 4'b0;
      rd_db_err <= 4'b0;
    end
  end

  // Scrub FSM next state; a new sb line is only taken while idle.
  always_comb begin
    state_n = state_r;
    pend_n  = pend_r;
    cws_n   = cws_r;
    line_n  = line_r;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|sb_mask_s) begin
          pend_n  = sb_mask_s;
          cws_n   = cw_fix_s;
          line_n  = req_addr_r[AW-1:2];
          state_n = ST_WB;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WB: begin
        drop_s = |sb_mask_s;
        if (wb_gnt) begin
          pend_n = pend_r & ~(4'b0001 << low_idx(pend_r));
        end else begin
          pend_n = pend_r;
        end
        if (pend_n == 4'b0) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WB;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pend_n  = 4'b0;
      end
    endcase
    idx_n = low_idx(pend_n);
  end

  // Scrub state and the held write request for the lowest pending word.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r <= ST_IDLE;
      pend_r  <= 4'b0;
      cws_r   <= '0;
      line_r  <= '0;
      wb_req  <= 1'b0;
      wb_addr <= '0;
      wb_data <= 78'b0;
    end else begin
      state_r <= state_n;
      pend_r  <= pend_n;
      cws_r   <= cws_n;
      line_r  <= line_n;
      wb_req  <= |pend_n;
      if (|pend_n) begin
        wb_addr <= {line_n, idx_n};
        wb_data <= {cws_n[idx_n], cws_n[idx_n]};
      end else begin
        wb_addr <= wb_addr;
        wb_data <= wb_data;
      end
    end
  end

  // Saturating error statistics.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sb_cnt   <= 16'b0;
      db_cnt   <= 16'b0;
      drop_cnt <= 16'b0;
    end else begin
      sb_cnt   <= sat_add(sb_cnt, popcnt4(sb_mask_s));
      db_cnt   <= sat_add(db_cnt, popcnt4(db_mask_s));
      drop_cnt <= sat_add(drop_cnt, drop_s ? popcnt4(sb_mask_s) : 3'd0);
    end
  end

endmodule

// File: tb/tb_ifu_iccm_ecc_scrub.sv
// Self-checking bench: directed vector table, hand sequences for scrub
// back-pressure / drop / reset / saturation, and a randomized phase.
module tb_ifu_iccm_ecc_scrub;

  localparam int AW = 14;
  localparam logic [5:0] NONE = 6'd63;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic [155:0]  iccm_rd_data;
  logic          rd_valid;
  logic [127:0]  rd_data;
  logic [3:0]    rd_sb_err, rd_db_err;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic [2:0]    wb_size;
  logic [77:0]   wb_data;
  logic          wb_gnt;
  logic [15:0]   sb_cnt, db_cnt, drop_cnt;

  ifu_iccm_ecc_scrub #(.ICCM_BITS(16)) dut (
    .clk(clk), .rst_l(rst_l), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .iccm_rd_data(iccm_rd_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_sb_err(rd_sb_err), .rd_db_err(rd_db_err), .wb_req(wb_req), .wb_addr(wb_addr),
    .wb_size(wb_size), .wb_data(wb_data), .wb_gnt(wb_gnt), .sb_cnt(sb_cnt),
    .db_cnt(db_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [3:0][31:0]    d;
    logic [3:0][38:0]    clean;
    logic [3:0][38:0]    raw;
    logic [3:0][1:0]     nfl;
  } line_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [38:0]   cw;
  } wb_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [3:0][31:0] d;
    logic [3:0][5:0]  fa;
    logic [3:0][5:0]  fb;
    logic [3:0]       xsb;
    logic [3:0]       xdb;
  } vec_t;

  int    n_chk = 0;
  int    n_pass = 0;
  line_t stg;
  bit    stg_v = 1'b0;
  bit    exp_v = 1'b0;
  logic [127:0] exp_data;
  logic [3:0]   exp_sb, exp_db;
  wb_t   q[$];
  int    m_sb = 0, m_db = 0, m_drop = 0;

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] pos;
    logic [38:0] cw;
    int j;
    pos = '0;
    j = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[j];
        j++;
      end
    end
    cw = {7'b0, d};
    for (int k = 0; k < 6; k++)
      for (int p = 1; p < 39; p++)
        if (p[k]) cw[32+k] = cw[32+k] ^ pos[p];
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  function automatic line_t build(input logic [AW-1:0] a, input logic [3:0][31:0] d,
                                  input logic [3:0][5:0] fa, input logic [3:0][5:0] fb);
    line_t l;
    l.addr = a;
    l.d = d;
    for (int w = 0; w < 4; w++) begin
      l.clean[w] = enc(d[w]);
      l.raw[w] = l.clean[w];
      l.nfl[w] = 2'd0;
      if (fa[w] != NONE) begin
        l.raw[w] = l.raw[w] ^ (39'b1 << fa[w]);
        l.nfl[w] = l.nfl[w] + 2'd1;
      end
      if (fb[w] != NONE) begin
        l.raw[w] = l.raw[w] ^ (39'b1 << fb[w]);
        l.nfl[w] = l.nfl[w] + 2'd1;
      end
    end
    return l;
  endfunction

  function automatic line_t rnd_line(input int max_flips);
    logic [3:0][31:0] d;
    logic [3:0][5:0]  fa, fb;
    int r;
    int a;
    for (int w = 0; w < 4; w++) begin
      d[w] = $urandom;
      fa[w] = NONE;
      fb[w] = NONE;
      r = (max_flips < 0) ? 7 : $urandom_range(0, 9);
      if (r >= 6) begin
        a = $urandom_range(0, 38);
        fa[w] = 6'(a);
        if (r >= 8) fb[w] = 6'((a + 1 + $urandom_range(0, 37)) % 39);
      end
    end
    return build(AW'($urandom), d, fa, fb);
  endfunction

  function automatic vec_t mkv(input logic [AW-1:0] a, input logic [3:0][31:0] d,
                               input logic [3:0][5:0] fa, input logic [3:0][5:0] fb,
                               input logic [3:0] xsb, input logic [3:0] xdb);
    vec_t v;
    v.addr = a; v.d = d; v.fa = fa; v.fb = fb; v.xsb = xsb; v.xdb = xdb;
    return v;
  endfunction

  function automatic int sat(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  // One clock: check outputs against the model, advance the model across the
  // coming edge, then drive this cycle's inputs.
  task automatic cyc(input bit v, input line_t ln, input bit g);
    bit busy;
    logic [3:0] sbm, dbm;
    logic [127:0] dat;
    @(negedge clk);
    chk("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      chk("rd_data", rd_data, exp_data);
      chk("rd_sb_err", rd_sb_err, exp_sb);
      chk("rd_db_err", rd_db_err, exp_db);
    end
    chk("wb_req", wb_req, q.size() != 0);
    if (q.size() != 0) begin
      chk("wb_addr", wb_addr, q[0].a);
      chk("wb_data", wb_data, {q[0].cw, q[0].cw});
      chk("wb_size", wb_size, 3'b010);
    end
    chk("sb_cnt", sb_cnt, m_sb);
    chk("db_cnt", db_cnt, m_db);
    chk("drop_cnt", drop_cnt, m_drop);

    busy = (q.size() != 0);
    if (busy && g) void'(q.pop_front());
    exp_v = stg_v;
    if (stg_v) begin
      sbm = 4'b0; dbm = 4'b0; dat = '0;
      for (int w = 0; w < 4; w++) begin
        if (stg.nfl[w] == 2'd0) begin
          dat[w*32 +: 32] = stg.d[w];
        end else if (stg.nfl[w] == 2'd1) begin
          dat[w*32 +: 32] = stg.d[w];
          sbm[w] = 1'b1;
        end else begin
          dat[w*32 +: 32] = stg.raw[w][31:0];
          dbm[w] = 1'b1;
        end
      end
      exp_data = dat; exp_sb = sbm; exp_db = dbm;
      m_sb = sat(m_sb, $countones(sbm));
      m_db = sat(m_db, $countones(dbm));
      if (sbm != 4'b0) begin
        if (busy) m_drop = sat(m_drop, $countones(sbm));
        else
          for (int w = 0; w < 4; w++)
            if (sbm[w]) q.push_back('{a: {stg.addr[AW-1:2], 2'(w)}, cw: stg.clean[w]});
      end
    end

    iccm_rd_data = stg_v ? {stg.raw[3], stg.raw[2], stg.raw[1], stg.raw[0]}
                         : 156'({$urandom, $urandom, $urandom, $urandom, $urandom});
    stg = ln;
    stg_v = v;
    rd_req_valid = v;
    rd_req_addr = ln.addr;
    wb_gnt = g;
  endtask

  vec_t  vecs [5];
  line_t idle, ln, lb;
  logic [3:0][5:0] nf;

  initial begin
    nf = {NONE, NONE, NONE, NONE};
    idle = build('0, '0, nf, nf);
    vecs[0] = mkv(14'h10, {32'hFFFFFFFF, 32'hDEADBEEF, 32'h1, 32'h0}, nf, nf, 4'b0000, 4'b0000);
    vecs[1] = mkv(14'h40, {32'h55AA55AA, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678},
                  {NONE, 6'd5, NONE, NONE}, nf, 4'b0100, 4'b0000);
    vecs[2] = mkv(14'h84, {32'hCAFEF00D, 32'h0, 32'h1, 32'h80000001},
                  {6'd3, NONE, NONE, 6'd38}, {6'd17, NONE, NONE, NONE}, 4'b0001, 4'b1000);
    vecs[3] = mkv(14'h3FFC, {32'hFFFF0000, 32'h7, 32'hA5A5A5A5, 32'h3C3C3C3C},
                  {6'd31, NONE, 6'd32, NONE}, nf, 4'b1010, 4'b0000);
    vecs[4] = mkv(14'h2A8, {32'h1111, 32'h2222, 32'h3333, 32'h4444},
                  {NONE, 6'd33, NONE, 6'd0}, {NONE, 6'd38, NONE, 6'd1}, 4'b0000, 4'b0101);

    rst_l = 1'b0; rd_req_valid = 1'b0; rd_req_addr = '0; iccm_rd_data = '0; wb_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 128'b0);
    chk("rst_wb_req", wb_req, 1'b0);
    chk("rst_wb_data", wb_data, 78'b0);
    chk("rst_sb_cnt", sb_cnt, 16'b0);
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ln = build(vecs[i].addr, vecs[i].d, vecs[i].fa, vecs[i].fb);
      cyc(1'b1, ln, 1'b1);
      cyc(1'b0, idle, 1'b1);
      @(posedge clk);
      #1;
      chk("tbl_sb", rd_sb_err, vecs[i].xsb);
      chk("tbl_db", rd_db_err, vecs[i].xdb);
      repeat (6) cyc(1'b0, idle, 1'b1);
    end

    // Words 1 and 3 pending; grant withheld five cycles then given twice.
    ln = build(14'h100, {32'h13572468, 32'hFEDCBA98, 32'h0BADBEEF, 32'h600DF00D},
               {6'd20, NONE, 6'd35, NONE}, nf);
    cyc(1'b1, ln, 1'b0);
    repeat (6) cyc(1'b0, idle, 1'b0);
    repeat (2) cyc(1'b0, idle, 1'b1);
    repeat (3) cyc(1'b0, idle, 1'b0);

    // Second sb line while writes are pending is dropped; then reset mid-scrub.
    ln = build(14'h200, {32'h1, 32'h2, 32'h3, 32'h4}, {NONE, 6'd9, NONE, 6'd30}, nf);
    lb = build(14'h300, {32'h5, 32'h6, 32'h7, 32'h8}, {NONE, NONE, 6'd12, NONE}, nf);
    cyc(1'b1, ln, 1'b0);
    cyc(1'b0, idle, 1'b0);
    cyc(1'b1, lb, 1'b0);
    cyc(1'b0, idle, 1'b0);
    cyc(1'b0, idle, 1'b0);
    @(posedge clk);
    #1;
    chk("drop_once", drop_cnt, 16'd1);
    chk("wb_busy", wb_req, 1'b1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_wb_req", wb_req, 1'b0);
    chk("mid_rst_wb_addr", wb_addr, '0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_sb_cnt", sb_cnt, 16'b0);
    chk("mid_rst_drop_cnt", drop_cnt, 16'b0);
    q.delete();
    m_sb = 0; m_db = 0; m_drop = 0;
    exp_v = 1'b0; stg_v = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) != 0, rnd_line(2), $urandom_range(0, 3) != 0);
    repeat (12) cyc(1'b0, idle, 1'b1);

    // Four single-bit words per line drive the corrected count into saturation.
    for (int i = 0; i < 16400; i++) cyc(1'b1, rnd_line(-1), 1'b1);
    repeat (8) cyc(1'b0, idle, 1'b1);
    @(posedge clk);
    #1;
    chk("sb_sat", sb_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifu_iccm_ecc_scrub.md
# ifu_iccm_ecc_scrub

Downstream consumer of the ICCM bank array read port. Takes the 156-bit, four-codeword read line one cycle after each ICCM read, runs SECDED check/correct on each 39-bit codeword, and registers the corrected 128-bit fetch data with per-word error flags. Corrected codewords for single-bit errors are queued and written back through the ICCM write port as word-size scrub writes under a req/gnt handshake.

## Interface
Parameters:
- ICCM_BITS, 16, byte-address width of ICCM; word address is [ICCM_BITS-1:2]

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- rd_req_valid  in  1  ICCM read issued this cycle (same cycle as ICCM rden)
- rd_req_addr  in  ICCM_BITS-2  word address [ICCM_BITS-1:2] of that read
- iccm_rd_data  in  156  ICCM read line, valid the cycle after rd_req_valid
- rd_valid  out  1  corrected line valid
- rd_data  out  128  corrected data, word w at [32w+31:32w]
- rd_sb_err  out  4  per-word single-bit error corrected
- rd_db_err  out  4  per-word uncorrectable error
- wb_req  out  1  scrub write request
- wb_addr  out  ICCM_BITS-2  scrub word address
- wb_size  out  3  constant 3'b010
- wb_data  out  78  corrected codeword replicated in [38:0] and [77:39]
- wb_gnt  in  1  scrub write accepted this cycle
- sb_cnt  out  16  saturating count of corrected words
- db_cnt  out  16  saturating count of uncorrectable words
- drop_cnt  out  16  saturating count of single-bit words not scrubbed

## Operation
- Line layout: word 0 = [38:0], 1 = [77:39], 2 = [116:78], 3 = [155:117]. Codeword: [31:0] data, [38:32] ecc[6:0].
- Hamming layout: data bits in order at non-power-of-two positions 3,5,6,7,9..38. ecc[k], k=0..5, at position 2^k, is XOR of all positions with bit k set. ecc[6] is XOR of all 38 other bits.
- Decode per word: s = recomputed ecc[5:0] XOR stored; p = XOR of all 39 bits.
  - s==0, p==0: clean.
  - p==1, s in 0..38: single-bit error; flip position s (s==0 flips bit 38).
  - p==1, s>38, or s!=0 with p==0: double-bit error; pass data unmodified.
- Scrub FSM has two states.
  - IDLE: on a registered line with any sb bit set, load pend_mask = sb mask (words with db excluded), corrected codewords, and line address [ICCM_BITS-1:4]. Go to WB.
  - WB: wb_req=1 for the lowest set pend_mask bit. wb_addr = {line, idx[1:0]}. On wb_gnt, clear that bit. When the mask empties, go to IDLE.
- A line with sb errors arriving while in WB, including the cycle wb_gnt clears the last bit, is not scrubbed. drop_cnt += number of its sb words.
- Counters add per-word popcounts and saturate at 16'hFFFF.

## Timing
- rd_req_valid at cycle N; capture address at N; decode iccm_rd_data combinationally at N+1; rd_valid, rd_data and error flags registered, visible at N+2 for one cycle.
- Fully pipelined: back-to-back reads give back-to-back rd_valid.
- wb_req first asserts at N+2, the same edge as rd_valid. It holds with stable addr/data until wb_gnt. At most one write completes per cycle.
- Reset values (asynchronous): rd_valid, rd_data, rd_sb_err, rd_db_err, wb_req, wb_addr, wb_data, pend_mask, all counters = 0; state IDLE. wb_size is constant.
- Reset mid-scrub discards pending writes; no partial write is issued.
- rd_req_valid with rd_req_addr only; the address pipeline holds no other state.

## Structure
- Shared package: codeword width (39), line width (156), words per line (4), FSM state enum, syndrome-position-to-bit-index function.
- Sub-module ifu_iccm_ecc_dec, instantiated 4x: 39-bit codeword in; corrected codeword, sb, db out. Purely combinational.

## Test plan
- Clean line, data words 32'h0,32'h1,32'hDEADBEEF,32'hFFFFFFFF with correct ECC, read at addr 0x10 -> rd_valid at N+2, exact data, flags 0, no wb_req.
- Flip data bit 5 of word 2, line addr word 0x40 -> rd_sb_err=4'b0100, corrected data, wb_req at N+2 with wb_addr=0x42, clean codeword in both wb_data halves; sb_cnt=1.
- Flip ecc[6] in word 0 and two data bits in word 3 -> sb=4'b0001, db=4'b1000, exactly one scrub write (word 0), db_cnt=1.
- sb errors in words 1 and 3, wb_gnt held low 5 cycles then high 2 cycles -> word 1 write then word 3 write, FSM returns to IDLE.
- During pending WB, second line with one sb error -> drop_cnt=1, no write for it; assert rst_l low mid-WB -> wb_req drops immediately, all outputs 0.
- Preload sb_cnt near 16'hFFFF, inject 4-sb line -> saturates at 16'hFFFF.
